// File: rtl/piezo_pkg.sv
// Shared types and constants for the piezo tone output stage and the note sequencer.
package piezo_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ATTACK,
        DECAY,
        SUSTAIN,
        RELEASE
    } env_state_t;

    localparam int ACC_W_DEF         = 32;
    localparam int INC_W_DEF         = 18;
    localparam int ENV_W_DEF         = 8;
    localparam int ENV_STEP_DEF      = 1000;
    localparam int SUSTAIN_LEVEL_DEF = 192;

    // Phase increments for a 32-bit accumulator; the sequencer indexes these.
    localparam logic [INC_W_DEF-1:0] NOTE_C  = 18'd11237;
    localparam logic [INC_W_DEF-1:0] NOTE_D  = 18'd12613;
    localparam logic [INC_W_DEF-1:0] NOTE_E  = 18'd14157;
    localparam logic [INC_W_DEF-1:0] NOTE_FS = 18'd15891;
    localparam logic [INC_W_DEF-1:0] NOTE_G  = 18'd16836;
    localparam logic [INC_W_DEF-1:0] NOTE_A  = 18'd18898;
    localparam logic [INC_W_DEF-1:0] NOTE_B  = 18'd21212;
    localparam logic [INC_W_DEF-1:0] NOTE_D5 = 18'd25225;

endpackage

// File: rtl/piezo_pwm_gate.sv
// PWM loudness gate: a free-running counter compared against the envelope level
// chops the square wave; MUTE forces the registered speaker drive low.
module piezo_pwm_gate #(
    parameter int ENV_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             square_i,
    input  logic [ENV_W-1:0] level_i,
    input  logic             mute_i,
    output logic             speaker_o
);

    logic [ENV_W-1:0] pwm_cnt_q;
    logic             speaker_q;

    // Strict less-than: level 0 never fires, full scale leaves one slot dark.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pwm_cnt_q <= '0;
            speaker_q <= 1'b0;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + 1'b1;
            speaker_q <= square_i & (pwm_cnt_q < level_i) & ~mute_i;
        end
    end

    assign speaker_o = speaker_q;

endmodule

// File: rtl/piezo_tone_envelope.sv
// Tone generator for the piezo speaker: phase-accumulator square wave shaped by an
// ADSR envelope. Note handshake: a note transfers on a clock where NOTE_VALID && NOTE_READY.
module piezo_tone_envelope
    import piezo_pkg::*;
#(
    parameter int ACC_W         = ACC_W_DEF,
    parameter int INC_W         = INC_W_DEF,
    parameter int ENV_W         = ENV_W_DEF,
    parameter int ENV_STEP      = ENV_STEP_DEF,
    parameter int SUSTAIN_LEVEL = SUSTAIN_LEVEL_DEF
) (
    input  logic             USER_CLK,
    input  logic             USER_RST_N,
    input  logic [INC_W-1:0] NOTE_INC,
    input  logic             NOTE_VALID,
    output logic             NOTE_READY,
    input  logic             NOTE_OFF,
    input  logic             MUTE,
    output logic             PIEZO_SPEAKER,
    output logic [ENV_W-1:0] ENV_LEVEL,
    output logic             BUSY,
    output env_state_t       DBG_STATE
);

    localparam int               STEP_W    = (ENV_STEP > 1) ? $clog2(ENV_STEP) : 1;
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(ENV_STEP - 1);
    localparam logic [ENV_W-1:0] FULL_LVL  = '1;
    localparam logic [ENV_W-1:0] SUS_LVL   = ENV_W'(SUSTAIN_LEVEL);

    env_state_t        state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [INC_W-1:0]  inc_q, inc_d;
    logic [ENV_W-1:0]  level_q, level_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic              busy_q;
    logic              accept;
    logic              tick;

    assign NOTE_READY = (state_q != ATTACK);
    assign accept     = NOTE_VALID & NOTE_READY;
    assign tick       = (step_q == STEP_LAST);

    always_ff @(posedge USER_CLK or negedge USER_RST_N) begin
        if (!USER_RST_N) begin
            state_q <= IDLE;
            acc_q   <= '0;
            inc_q   <= '0;
            level_q <= '0;
            step_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            inc_q   <= inc_d;
            level_q <= level_d;
            step_q  <= step_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    always_comb begin
        state_d = state_q;
        inc_d   = inc_q;
        level_d = level_q;
        step_d  = tick ? '0 : step_q + 1'b1;

        // An accepted note takes priority over NOTE_OFF and over any envelope tick.
        if (accept) begin
            step_d = '0;
            if (NOTE_INC != '0) begin
                inc_d   = NOTE_INC;
                state_d = ATTACK;
            end else if (state_q != IDLE) begin
                state_d = RELEASE;
            end
        end else begin
            unique case (state_q)
                ATTACK: begin
                    if (tick) begin
                        if (level_q >= FULL_LVL - 1'b1) begin
                            level_d = FULL_LVL;
                            state_d = DECAY;
                        end else begin
                            level_d = level_q + 1'b1;
                        end
                    end
                end
                DECAY: begin
                    if (tick) begin
                        if (level_q <= SUS_LVL + 1'b1) begin
                            level_d = SUS_LVL;
                            state_d = SUSTAIN;
                        end else begin
                            level_d = level_q - 1'b1;
                        end
                    end
                    if (NOTE_OFF) begin
                        state_d = RELEASE;
                    end
                end
                SUSTAIN: begin
                    if (NOTE_OFF) begin
                        state_d = RELEASE;
                    end
                end
                RELEASE: begin
                    if (tick) begin
                        if (level_q <= 1) begin
                            level_d = '0;
                            state_d = IDLE;
                        end else begin
                            level_d = level_q - 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end

        // Phase runs continuously across note changes; it only restarts via IDLE.
        if ((state_q == IDLE) || (state_d == IDLE)) begin
            acc_d = '0;
        end else begin
            acc_d = acc_q + ACC_W'(inc_q);
        end
    end

    piezo_pwm_gate #(
        .ENV_W (ENV_W)
    ) u_pwm_gate (
        .clk_i     (USER_CLK),
        .rst_ni    (USER_RST_N),
        .square_i  (acc_q[ACC_W-1]),
        .level_i   (level_q),
        .mute_i    (MUTE),
        .speaker_o (PIEZO_SPEAKER)
    );

    assign ENV_LEVEL = level_q;
    assign BUSY      = busy_q;
    assign DBG_STATE = state_q;

endmodule
